// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter stage of the 9-bit CPU.
package pc_seq_pkg;

   localparam int PC_W_DEF  = 8;
   localparam int OFF_W_DEF = 4;
   localparam int CNT_W_DEF = 16;
   localparam int REG_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_FWD  = 2'd1,
      BR_BWD  = 2'd2
   } br_kind_e;

   // A jump is taken only for exactly one jump decode; both at once is an
   // illegal encoding and falls through to pc+1.
   function automatic logic branch_taken(input logic jizr,
                                         input logic jnzr,
                                         input logic reg_zero);
      return (jizr && !jnzr && reg_zero) || (jnzr && !jizr && !reg_zero);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake and fetch bus between the top level and the PC sequencer.
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic               start;
   logic               stall;
   logic               halt;
   logic               jizr;
   logic               jnzr;
   logic               dir_back;
   logic [OFF_W-1:0]   offset;
   logic [REG_W-1:0]   reg_val;
   logic [PC_W-1:0]    pc;
   logic               fetch_valid;
   logic               done;
   logic [CNT_W-1:0]   retired;

   // Top level / testbench side: drives control and decode, observes fetch.
   modport master (
      output start, stall, halt, jizr, jnzr, dir_back, offset, reg_val,
      input  pc, fetch_valid, done, retired
   );

   // Sequencer side.
   modport slave (
      input  start, stall, halt, jizr, jnzr, dir_back, offset, reg_val,
      output pc, fetch_valid, done, retired
   );

endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// Next fetch address: pc+1, or pc +/- 2*offset for a taken jump, mod 2^PC_W.
module pc_next_calc
   import pc_seq_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [OFF_W-1:0] offset,
   input  logic             dir_back,
   input  logic             taken,
   output logic [PC_W-1:0]  pc_next
);

   logic [PC_W-1:0] disp;
   br_kind_e        kind;

   // Offset is in units of two instructions; zero-extend the scaled value.
   assign disp = PC_W'({offset, 1'b0});

   // Select the branch kind, then the matching address; wrap is natural.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      kind    = BR_NONE;
      pc_next = pc + PC_W'(1);
      if (taken) begin
         kind = dir_back ? BR_BWD : BR_FWD;
      end
      unique case (kind)
         BR_FWD:  pc_next = pc + disp;
         BR_BWD:  pc_next = pc - disp;
         default: pc_next = pc + PC_W'(1);
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// PC stage: IDLE/RUN/DONE sequencing, jump resolution, retired counter.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int OFF_W      = OFF_W_DEF,
   parameter int START_ADDR = 0,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              done_q, done_d;

   logic              taken;
   logic [PC_W-1:0]   pc_next;
   logic [CNT_W-1:0]  retired_inc;

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   // Jump resolution for the instruction at the current pc.
   assign taken = branch_taken(bus.jizr, bus.jnzr, bus.reg_val == '0);

   // Retired count saturates at all-ones instead of wrapping.
   assign retired_inc = (retired_q == {CNT_W{1'b1}}) ? retired_q
                                                     : retired_q + CNT_W'(1);

   pc_next_calc #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_next (
      .pc       (pc_q),
      .offset   (bus.offset),
      .dir_back (bus.dir_back),
      .taken    (taken),
      .pc_next  (pc_next)
   );

   // Next-state, next-pc and counter decisions; outputs follow the next state.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d   = RUN;
               pc_d      = START_PC;
               retired_d = '0;
            end
         end
         RUN: begin
            // A stall freezes everything, including a pending halt.
            if (!bus.stall) begin
               retired_d = retired_inc;
               if (bus.halt) begin
                  state_d = DONE;
               end else begin
                  pc_d = pc_next;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      fetch_valid_d = (state_d == RUN);
      done_d        = (state_d == DONE);
   end

   // All state and registered outputs; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= START_PC;
         retired_q     <= '0;
         fetch_valid_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         retired_q     <= retired_d;
         fetch_valid_q <= fetch_valid_d;
         done_q        <= done_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.done        = done_q;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer and pc_next_calc.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_W(8), .OFF_W(4), .CNT_W(16)) bus ();
   pc_sequencer_if #(.PC_W(8), .OFF_W(4), .CNT_W(3))  bus_s ();

   pc_sequencer #(.PC_W(8), .OFF_W(4), .START_ADDR(0), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Narrow counter instance used only to reach saturation quickly.
   pc_sequencer #(.PC_W(8), .OFF_W(4), .START_ADDR(0), .CNT_W(3)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   logic [7:0] c_pc;
   logic [3:0] c_off;
   logic       c_back;
   logic       c_taken;
   logic [7:0] c_next;

   pc_next_calc #(.PC_W(8), .OFF_W(4)) u_calc (
      .pc       (c_pc),
      .offset   (c_off),
      .dir_back (c_back),
      .taken    (c_taken),
      .pc_next  (c_next)
   );

   typedef struct packed {
      logic        start;
      logic        stall;
      logic        halt;
      logic        jizr;
      logic        jnzr;
      logic        dir_back;
      logic [3:0]  offset;
      logic [7:0]  reg_val;
      logic [7:0]  exp_pc;
      logic [15:0] exp_ret;
      logic        exp_fv;
      logic        exp_done;
   } vec_t;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] ret;
      logic        fv;
      logic        done;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   function automatic vec_t v(input int st, input int sl, input int h,
                              input int jz, input int jn, input int db,
                              input int off, input int rv, input int pc,
                              input int r, input int fv, input int d);
      vec_t t;
      t.start    = st[0];
      t.stall    = sl[0];
      t.halt     = h[0];
      t.jizr     = jz[0];
      t.jnzr     = jn[0];
      t.dir_back = db[0];
      t.offset   = off[3:0];
      t.reg_val  = rv[7:0];
      t.exp_pc   = pc[7:0];
      t.exp_ret  = r[15:0];
      t.exp_fv   = fv[0];
      t.exp_done = d[0];
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.start    = t.start;
      bus.stall    = t.stall;
      bus.halt     = t.halt;
      bus.jizr     = t.jizr;
      bus.jnzr     = t.jnzr;
      bus.dir_back = t.dir_back;
      bus.offset   = t.offset;
      bus.reg_val  = t.reg_val;
   endtask

   // Pop the oldest expectation and compare it with the registered outputs.
   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_pc"},   32'(bus.pc),          32'(e.pc));
         check({tag, "_ret"},  32'(bus.retired),     32'(e.ret));
         check({tag, "_fv"},   32'(bus.fetch_valid), 32'(e.fv));
         check({tag, "_done"}, 32'(bus.done),        32'(e.done));
      end
   endtask

   // One cycle: drive at the falling edge, sample 1 time unit after rising.
   task automatic apply(input vec_t t, input logic rst, input string tag);
      @(negedge clk);
      drive(t);
      reset = rst;
      sb.push_back({t.exp_pc, t.exp_ret, t.exp_fv, t.exp_done});
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   initial begin
      int exp_next;
      int exp_sat;

      // columns: start stall halt jizr jnzr back off reg | pc ret fv done
      vecs.push_back(v(0,0,0,1,0,0, 3,  0, 'h00, 0,0,0)); // IDLE ignores decode
      vecs.push_back(v(1,0,0,0,0,0, 0,  0, 'h00, 0,1,0)); // start
      for (int i = 1; i <= 5; i++)
         vecs.push_back(v(0,0,0,0,0,0, 0, 0, i, i, 1, 0));
      vecs.push_back(v(0,0,0,0,1,0, 5,  1, 'h0F, 6,1,0)); // jnzr fwd 10
      vecs.push_back(v(1,0,0,0,0,0, 0,  0, 'h10, 7,1,0)); // start in RUN ignored
      vecs.push_back(v(0,0,0,1,0,0, 3,  0, 'h16, 8,1,0)); // jizr taken fwd
      vecs.push_back(v(0,0,0,1,0,1, 3,  0, 'h10, 9,1,0)); // jizr taken back
      vecs.push_back(v(0,0,0,1,0,0, 3,  7, 'h11,10,1,0)); // jizr not taken
      vecs.push_back(v(0,0,0,1,0,1, 7,  0, 'h03,11,1,0)); // back 14
      vecs.push_back(v(0,0,0,0,1,1, 2,  1, 'hFF,12,1,0)); // wrap below zero
      vecs.push_back(v(0,0,0,0,0,0, 0,  0, 'h00,13,1,0)); // 0xFF+1 wraps
      vecs.push_back(v(0,0,0,1,1,0, 4,  0, 'h01,14,1,0)); // illegal, zero reg
      vecs.push_back(v(0,0,0,1,1,0, 4,  1, 'h02,15,1,0)); // illegal, nonzero reg
      vecs.push_back(v(0,0,0,0,1,0,15,  0, 'h03,16,1,0)); // jnzr not taken
      vecs.push_back(v(0,0,0,1,0,1, 0,  0, 'h03,17,1,0)); // taken offset 0
      vecs.push_back(v(0,0,0,0,1,0,14,'h80,'h1F,18,1,0)); // fwd 28
      vecs.push_back(v(0,0,0,0,0,0, 0,  0, 'h20,19,1,0));
      for (int i = 0; i < 3; i++)                         // stall beats halt/jump
         vecs.push_back(v(0,1,1,1,0,0, 5, 0, 'h20,19,1,0));
      vecs.push_back(v(0,0,1,1,0,0, 5,  0, 'h20,20,0,1)); // halt beats jizr
      vecs.push_back(v(0,0,0,0,1,0, 3,  1, 'h20,20,0,1)); // DONE frozen
      vecs.push_back(v(1,0,0,0,0,0, 0,  0, 'h00, 0,1,0)); // restart from DONE
      vecs.push_back(v(0,0,0,0,0,0, 0,  0, 'h01, 1,1,0));
      vecs.push_back(v(0,0,1,0,1,0, 6,  5, 'h01, 2,0,1)); // halt beats jnzr
      vecs.push_back(v(1,0,0,0,0,0, 0,  0, 'h00, 0,1,0));
      vecs.push_back(v(0,0,0,1,0,1, 8,  0, 'hF0, 1,1,0)); // 0x00-16
      vecs.push_back(v(0,0,0,1,0,0,15,  0, 'h0E, 2,1,0)); // 0xF0+30 wraps
      vecs.push_back(v(0,0,0,0,1,0,15,  3, 'h2C, 3,1,0));
      vecs.push_back(v(0,0,0,0,1,0,11,  3, 'h42, 4,1,0));

      reset = 1'b1;
      drive(v(0,0,0,0,0,0,0,0,0,0,0,0));
      bus_s.start = 1'b0; bus_s.stall = 1'b0; bus_s.halt = 1'b0;
      bus_s.jizr = 1'b0; bus_s.jnzr = 1'b0; bus_s.dir_back = 1'b0;
      bus_s.offset = '0; bus_s.reg_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",   32'(bus.pc),          32'h0);
      check("rst_ret",  32'(bus.retired),     32'h0);
      check("rst_fv",   32'(bus.fetch_valid), 32'h0);
      check("rst_done", 32'(bus.done),        32'h0);

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], 1'b0, $sformatf("v%0d", i));

      // Reset mid-RUN at 0x42 with a taken jump pending: no partial update.
      apply(v(0,0,0,1,0,0,5,0, 'h00,0,0,0), 1'b1, "rst_run");
      apply(v(0,0,0,1,0,0,5,0, 'h00,0,0,0), 1'b0, "post_rst_idle");
      apply(v(1,0,0,0,0,0,0,0, 'h00,0,1,0), 1'b0, "restart");
      apply(v(1,0,0,1,0,0,2,0, 'h04,1,1,0), 1'b0, "start_in_run");

      // Saturation of a 3-bit retired counter.
      @(negedge clk);
      bus_s.start = 1'b1;
      @(posedge clk);
      #1;
      check("sat_start", 32'(bus_s.retired), 32'd0);
      @(negedge clk);
      bus_s.start = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         exp_sat = (n > 7) ? 7 : n;
         check($sformatf("sat_%0d", n), 32'(bus_s.retired), 32'(exp_sat));
      end

      // Exhaustive sweep of the next-address block against integer arithmetic.
      for (int p = 0; p < 256; p++) begin
         for (int o = 0; o < 16; o++) begin
            for (int b = 0; b < 2; b++) begin
               for (int t = 0; t < 2; t++) begin
                  c_pc    = p[7:0];
                  c_off   = o[3:0];
                  c_back  = b[0];
                  c_taken = t[0];
                  #1;
                  if (t == 0)      exp_next = (p + 1) % 256;
                  else if (b == 1) exp_next = (p - 2 * o + 256) % 256;
                  else             exp_next = (p + 2 * o) % 256;
                  check($sformatf("calc_p%0d_o%0d_b%0d_t%0d", p, o, b, t),
                        32'(c_next), 32'(exp_next));
               end
            end
         end
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
